// File: rtl/spi_master_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_pkg
// Description : Shared types for the SPI master. Defines the controller state
//               encoding, the transfer-mode encoding ({cpol,cpha} mapped onto
//               mode-select values 1..4) and helpers to build and decode it.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_XFER  = 3'd2,
        ST_TRAIL = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    // Mode-select values: 1={cpol,cpha}=00, 2=10, 3=01, 4=11.
    typedef enum logic [2:0] {
        MODE_1 = 3'd1,
        MODE_2 = 3'd2,
        MODE_3 = 3'd3,
        MODE_4 = 3'd4
    } mode_t;

    function automatic mode_t mode_encode(input logic cpol, input logic cpha);
        case ({cpol, cpha})
            2'b00:   return MODE_1;
            2'b10:   return MODE_2;
            2'b01:   return MODE_3;
            default: return MODE_4;
        endcase
    endfunction

    function automatic logic mode_cpol(input mode_t mode);
        return (mode == MODE_2) || (mode == MODE_4);
    endfunction

    function automatic logic mode_cpha(input mode_t mode);
        return (mode == MODE_3) || (mode == MODE_4);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_clk_gen.sv
`default_nettype none
// ============================================================================
// Module      : spi_clk_gen
// Description : Half-period timer for the SPI master. Counts 0..i_div and
//               pulses o_tick on the last count, so one half-period lasts
//               i_div+1 clock cycles. Held at zero while disabled or cleared.
// Ports       : clk     - system clock
//               rstn    - synchronous active-low reset
//               i_en    - count enable (controller not idle)
//               i_clear - restart the half-period from zero
//               i_div   - terminal count (half-period minus one)
//               o_tick  - one-cycle pulse at the end of each half-period
// Revision    : 1.0 - initial release
// ============================================================================
module spi_clk_gen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_en,
    input  logic             i_clear,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_cnt;
    logic             w_at_end;

    // Counter is as wide as the divider, so a full-scale divider of all ones
    // reaches its terminal count exactly without wrapping first.
    assign w_at_end = (r_cnt == i_div);
    assign o_tick   = i_en && !i_clear && w_at_end;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (i_clear || !i_en || w_at_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// Module      : spi_master
// Description : SPI bus master supporting all four CPOL/CPHA modes, chosen
//               per transfer. Host handshake is start/busy/done with parallel
//               tx/rx words, MSB first on the wire.
// Ports       : clk      - system clock (posedge)
//               rstn     - synchronous active-low reset
//               cfg_cpol - sck idle level, latched at start
//               cfg_cpha - 0: sample on leading edge, 1: on trailing edge
//               cfg_div  - sck half-period = cfg_div+1 clocks
//               start    - transfer request, honoured only when not busy
//               tx_data  - word to send, latched at start
//               busy     - transfer in progress (through deselect gap)
//               done     - one-cycle pulse when rx_data is updated
//               rx_data  - last received word
//               sck/mosi/csn - SPI outputs, miso - SPI input (synchronous)
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master
    import spi_master_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cfg_cpol,
    input  logic              cfg_cpha,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sck,
    output logic              mosi,
    input  logic              miso,
    output logic              csn
);

    localparam int                  c_num_edges = 2 * DATA_W;
    localparam int                  c_edge_w    = $clog2(c_num_edges + 1);
    localparam logic [c_edge_w-1:0] c_last_edge = c_edge_w'(c_num_edges);

    state_t              r_state;
    mode_t               r_mode;
    logic [DIV_W-1:0]    r_div;
    logic [DATA_W-1:0]   r_tx_sr;
    logic [DATA_W-1:0]   r_rx_sr;
    logic [DATA_W-1:0]   r_rx_data;
    logic [c_edge_w-1:0] r_edge_cnt;
    logic                r_sck;
    logic                r_mosi;
    logic                r_csn;
    logic                r_busy;
    logic                r_done;

    logic                w_tick;
    logic                w_run;
    logic                w_accept;
    logic                w_cpol;
    logic                w_cpha;
    logic [c_edge_w-1:0] w_edge_k;
    logic                w_sample;

    assign w_run    = (r_state != ST_IDLE);
    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_cpol   = mode_cpol(r_mode);
    assign w_cpha   = mode_cpha(r_mode);

    // Number of the sck edge produced by the next tick; odd edges lead.
    // The first edge coincides with leaving LEAD, so LEAD is half-period 1.
    assign w_edge_k = r_edge_cnt + 1'b1;
    // Sample on leading edges in CPHA=0, on trailing edges in CPHA=1;
    // the other edge of each pair shifts out the next mosi bit.
    assign w_sample = w_edge_k[0] ^ w_cpha;

    spi_clk_gen #(
        .DIV_W (DIV_W)
    ) u_clk_gen (
        .clk     (clk),
        .rstn    (rstn),
        .i_en    (w_run),
        .i_clear (w_accept),
        .i_div   (r_div),
        .o_tick  (w_tick)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_mode     <= MODE_1;
            r_div      <= '0;
            r_tx_sr    <= '0;
            r_rx_sr    <= '0;
            r_rx_data  <= '0;
            r_edge_cnt <= '0;
            r_sck      <= 1'b0;
            r_mosi     <= 1'b0;
            r_csn      <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Follow the live polarity so sck is settled before csn falls.
                    r_sck <= cfg_cpol;
                    if (start) begin
                        r_state    <= ST_LEAD;
                        r_mode     <= mode_encode(cfg_cpol, cfg_cpha);
                        r_div      <= cfg_div;
                        r_edge_cnt <= '0;
                        r_rx_sr    <= '0;
                        r_csn      <= 1'b0;
                        r_busy     <= 1'b1;
                        if (cfg_cpha) begin
                            r_tx_sr <= tx_data;
                        end else begin
                            // CPHA=0 presents the MSB before the first edge.
                            r_mosi  <= tx_data[DATA_W-1];
                            r_tx_sr <= tx_data << 1;
                        end
                    end
                end

                ST_LEAD, ST_XFER: begin
                    if (w_tick) begin
                        r_sck      <= ~r_sck;
                        r_edge_cnt <= w_edge_k;
                        if (w_sample) begin
                            r_rx_sr <= {r_rx_sr[DATA_W-2:0], miso};
                        end else if (w_edge_k != c_last_edge) begin
                            // Final trailing edge in CPHA=0 has no bit left; mosi holds.
                            r_mosi  <= r_tx_sr[DATA_W-1];
                            r_tx_sr <= r_tx_sr << 1;
                        end
                        r_state <= (w_edge_k == c_last_edge) ? ST_TRAIL : ST_XFER;
                    end
                end

                ST_TRAIL: begin
                    r_sck <= w_cpol;
                    if (w_tick) begin
                        r_csn     <= 1'b1;
                        r_rx_data <= r_rx_sr;
                        r_done    <= 1'b1;
                        r_state   <= ST_GAP;
                    end
                end

                ST_GAP: begin
                    if (w_tick) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_csn   <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign rx_data = r_rx_data;
    assign sck     = r_sck;
    assign mosi    = r_mosi;
    assign csn     = r_csn;

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_master
// Description : Self-checking bench for spi_master. A behavioural SPI slave
//               and bus monitor sample the bus 2 time units after each
//               rising clock; directed and random transfers are compared
//               against expectations computed from the protocol rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master;

    localparam int DATA_W = 8;
    localparam int DIV_W  = 8;
    localparam int BUDGET = 6000;

    logic              clk      = 1'b0;
    logic              rstn     = 1'b0;
    logic              cfg_cpol = 1'b0;
    logic              cfg_cpha = 1'b0;
    logic [DIV_W-1:0]  cfg_div  = '0;
    logic              start    = 1'b0;
    logic [DATA_W-1:0] tx_data  = '0;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rx_data;
    logic              sck;
    logic              mosi;
    logic              miso     = 1'b0;
    logic              csn;

    int checks = 0;
    int errors = 0;

    // Slave model and bus monitor state
    logic       m_cpol = 1'b0, m_cpha = 1'b0;
    logic [7:0] slave_word = '0, slv_tx = '0, slv_rx = '0, slv_last = '0;
    logic       prev_csn = 1'b1, prev_sck = 1'b0, prev_busy = 1'b0;
    logic       sck_at_fall = 1'b0, sck_at_rise = 1'b0, lead = 1'b0;
    int cycle = 0, csn_falls = 0, done_count = 0;
    int low_cnt = 0, high_cnt = 0, last_low = 0, last_high = 0;
    int edge_cnt = 0, last_rise = -1, sck_period = 0;
    int busy_cnt = 0, busy_len = 0, done_cycle = 0, busy_fall_cycle = 0;

    spi_master #(
        .DATA_W (DATA_W),
        .DIV_W  (DIV_W)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .cfg_cpol (cfg_cpol),
        .cfg_cpha (cfg_cpha),
        .cfg_div  (cfg_div),
        .start    (start),
        .tx_data  (tx_data),
        .busy     (busy),
        .done     (done),
        .rx_data  (rx_data),
        .sck      (sck),
        .mosi     (mosi),
        .miso     (miso),
        .csn      (csn)
    );

    always #5 clk = ~clk;

    // Slave: loads its word when csn falls; in CPHA=0 it presents the MSB at
    // once. Sampling edge takes mosi, the other edge shifts the next miso bit.
    always @(posedge clk) begin
        #2;
        cycle++;
        if (busy && !prev_busy) busy_cnt = 0;
        if (busy) busy_cnt++;
        if (!busy && prev_busy) begin
            busy_len        = busy_cnt;
            busy_fall_cycle = cycle;
        end
        if (done) begin
            done_count++;
            done_cycle = cycle;
        end
        if (prev_csn && !csn) begin
            csn_falls++;
            last_high   = high_cnt;
            low_cnt     = 0;
            edge_cnt    = 0;
            last_rise   = -1;
            slv_rx      = '0;
            slv_tx      = slave_word;
            sck_at_fall = sck;
            if (!m_cpha) begin
                miso   = slv_tx[7];
                slv_tx = slv_tx << 1;
            end
        end else if (!csn && (sck != prev_sck)) begin
            edge_cnt++;
            lead = (sck != m_cpol);
            if (lead != m_cpha) begin
                slv_rx = {slv_rx[6:0], mosi};
            end else begin
                miso   = slv_tx[7];
                slv_tx = slv_tx << 1;
            end
            if (sck && !prev_sck) begin
                if (last_rise >= 0) sck_period = cycle - last_rise;
                last_rise = cycle;
            end
        end
        if (!prev_csn && csn) begin
            high_cnt    = 0;
            last_low    = low_cnt;
            sck_at_rise = sck;
            slv_last    = slv_rx;
        end
        if (csn) high_cnt++;
        else     low_cnt++;
        prev_csn  = csn;
        prev_sck  = sck;
        prev_busy = busy;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_xfer(input logic cpol, input logic cpha, input logic [7:0] div,
                           input logic [7:0] tx, input logic [7:0] sw, input bit scramble);
        @(negedge clk);
        cfg_cpol   = cpol;
        cfg_cpha   = cpha;
        cfg_div    = div;
        tx_data    = tx;
        m_cpol     = cpol;
        m_cpha     = cpha;
        slave_word = sw;
        @(negedge clk);
        check("idle_sck_before", 32'(sck), 32'(cpol));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (scramble) begin
            cfg_cpol = 1'($urandom);
            cfg_cpha = 1'($urandom);
            cfg_div  = 8'($urandom);
            tx_data  = 8'($urandom);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, 32'(n < BUDGET), 32'd1);
    endtask

    initial begin
        logic       rc, rp;
        logic [7:0] rd, rt, rs;
        int         f0, d0, n, hh;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("rst_csn",  32'(csn),     32'd1);
        check("rst_sck",  32'(sck),     32'd0);
        check("rst_mosi", 32'(mosi),    32'd0);
        check("rst_busy", 32'(busy),    32'd0);
        check("rst_done", 32'(done),    32'd0);
        check("rst_rx",   32'(rx_data), 32'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // ---- mode 1 (cpol=0,cpha=0), div=1 ----
        d0 = done_count;
        do_xfer(1'b0, 1'b0, 8'd1, 8'hA5, 8'h3C, 1'b1);
        wait_idle("m1");
        check("m1_slave_rx", 32'(slv_last), 32'h A5);
        check("m1_rx_data",  32'(rx_data),  32'h3C);
        check("m1_csn_low",  32'(last_low), 32'd34);
        check("m1_busy_len", 32'(busy_len), 32'd36);
        check("m1_done_cnt", 32'(done_count - d0), 32'd1);
        check("m1_busy_after_done", 32'(busy_fall_cycle - done_cycle), 32'd2);
        check("m1_edges", 32'(edge_cnt), 32'd16);

        // ---- remaining modes, tx=0x5A, slave 0xC3 ----
        for (int m = 0; m < 3; m++) begin
            rc = (m != 1);
            rp = (m != 0);
            rd = 8'($urandom_range(0, 2));
            d0 = done_count;
            do_xfer(rc, rp, rd, 8'h5A, 8'hC3, 1'b1);
            wait_idle($sformatf("mode%0d", m + 2));
            check($sformatf("mode%0d_slave_rx", m + 2), 32'(slv_last), 32'h5A);
            check($sformatf("mode%0d_rx_data", m + 2),  32'(rx_data),  32'hC3);
            check($sformatf("mode%0d_sck_fall", m + 2), 32'(sck_at_fall), 32'(rc));
            check($sformatf("mode%0d_sck_rise", m + 2), 32'(sck_at_rise), 32'(rc));
            check($sformatf("mode%0d_csn_low", m + 2),  32'(last_low), 32'(17 * (int'(rd) + 1)));
            check($sformatf("mode%0d_done", m + 2),     32'(done_count - d0), 32'd1);
        end

        // ---- divider extremes, miso tied low ----
        do_xfer(1'b0, 1'b0, 8'd0, 8'hFF, 8'h00, 1'b0);
        wait_idle("div0");
        check("div0_rx",     32'(rx_data),    32'h00);
        check("div0_slave",  32'(slv_last),   32'hFF);
        check("div0_period", 32'(sck_period), 32'd2);
        check("div0_low",    32'(last_low),   32'd17);
        do_xfer(1'b0, 1'b0, 8'd255, 8'hFF, 8'h00, 1'b0);
        wait_idle("div255");
        check("div255_rx",     32'(rx_data),    32'h00);
        check("div255_period", 32'(sck_period), 32'd512);
        check("div255_low",    32'(last_low),   32'd4352);
        check("div255_busy",   32'(busy_len),   32'd4608);
        check("div255_edges",  32'(edge_cnt),   32'd16);

        // ---- start while busy is ignored ----
        f0 = csn_falls;
        d0 = done_count;
        do_xfer(1'b0, 1'b0, 8'd1, 8'hA5, 8'h96, 1'b0);
        repeat (10) @(negedge clk);
        tx_data = 8'h11;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("busy_start");
        repeat (40) @(negedge clk);
        check("busy_start_slave", 32'(slv_last), 32'hA5);
        check("busy_start_rx",    32'(rx_data),  32'h96);
        check("busy_start_falls", 32'(csn_falls - f0), 32'd1);
        check("busy_start_done",  32'(done_count - d0), 32'd1);

        // ---- reset at edge 7 ----
        d0 = done_count;
        do_xfer(1'b0, 1'b0, 8'd1, 8'hA5, 8'h3C, 1'b0);
        n = 0;
        while (edge_cnt != 7 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rst7_edge_timeout", 32'(n < 200), 32'd1);
        rstn = 1'b0;
        @(negedge clk);
        check("rst7_csn",  32'(csn),     32'd1);
        check("rst7_sck",  32'(sck),     32'd0);
        check("rst7_rx",   32'(rx_data), 32'd0);
        check("rst7_busy", 32'(busy),    32'd0);
        rstn = 1'b1;
        repeat (40) @(negedge clk);
        check("rst7_no_done", 32'(done_count - d0), 32'd0);
        rs = 8'($urandom) | 8'h01;
        do_xfer(1'b0, 1'b0, 8'd1, 8'h81, rs, 1'b0);
        wait_idle("post_rst");
        check("post_rst_slave", 32'(slv_last), 32'h81);
        check("post_rst_rx",    32'(rx_data),  32'(rs));

        // ---- back-to-back: start in the first cycle busy is low ----
        d0 = done_count;
        do_xfer(1'b0, 1'b0, 8'd1, 8'h01, 8'h5C, 1'b0);
        wait_idle("b2b_first");
        tx_data    = 8'h80;
        slave_word = 8'hE7;
        start      = 1'b1;
        check("b2b_first_rx",    32'(rx_data),  32'h5C);
        check("b2b_first_slave", 32'(slv_last), 32'h01);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        wait_idle("b2b_second");
        check("b2b_done_cnt",     32'(done_count - d0), 32'd2);
        check("b2b_second_slave", 32'(slv_last), 32'h80);
        check("b2b_second_rx",    32'(rx_data),  32'hE7);
        check("b2b_gap_ge_h",     32'(last_high >= 2), 32'd1);

        // ---- random transfers against the protocol rules ----
        for (int i = 0; i < 6; i++) begin
            rc = 1'($urandom);
            rp = 1'($urandom);
            rd = 8'($urandom_range(0, 3));
            rt = 8'($urandom);
            rs = 8'($urandom);
            hh = int'(rd) + 1;
            d0 = done_count;
            do_xfer(rc, rp, rd, rt, rs, 1'b1);
            wait_idle($sformatf("rnd%0d", i));
            check($sformatf("rnd%0d_slave", i),    32'(slv_last), 32'(rt));
            check($sformatf("rnd%0d_rx", i),       32'(rx_data),  32'(rs));
            check($sformatf("rnd%0d_low", i),      32'(last_low), 32'((2 * DATA_W + 1) * hh));
            check($sformatf("rnd%0d_busy", i),     32'(busy_len), 32'((2 * DATA_W + 2) * hh));
            check($sformatf("rnd%0d_sck_fall", i), 32'(sck_at_fall), 32'(rc));
            check($sformatf("rnd%0d_sck_rise", i), 32'(sck_at_rise), 32'(rc));
            check($sformatf("rnd%0d_done", i),     32'(done_count - d0), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_master.md
Name: spi_master

Overview:
- Synthesizable SPI master that drives sck/mosi/csn and samples miso.
- Supports all four CPOL/CPHA modes, selected at runtime per transfer.
- It is the initiating end of the SPI link; the sim SPI slave model sits on the other end of the bus in system benches.
- The host side uses a start/busy/done handshake with parallel tx/rx words.

Parameters:
- DATA_W, 8, bits per transfer (MSB first).
- DIV_W, 8, width of the sck half-period divider.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rstn  input  1  synchronous active-low reset.
- cfg_cpol  input  1  sck idle level; latched at start.
- cfg_cpha  input  1  0: sample on leading edge; 1: sample on trailing edge. Latched at start.
- cfg_div  input  DIV_W  sck half-period = cfg_div+1 clk cycles. Latched at start.
- start  input  1  single-cycle request; accepted only when busy=0.
- tx_data  input  DATA_W  word to send; latched at start.
- busy  output  1  high from the cycle after an accepted start until the end of GAP.
- done  output  1  one-cycle pulse when rx_data is valid.
- rx_data  output  DATA_W  last received word; holds until the next done.
- sck  output  1  SPI clock.
- mosi  output  1  SPI data out.
- miso  input  1  SPI data in; already synchronous to clk in the bench and system.
- csn  output  1  active-low chip select.

Behaviour:
- Reset (rstn=0 at posedge): state=IDLE, csn=1, sck=0, mosi=0, busy=0, done=0, rx_data=0, counters=0. This applies equally mid-transfer: csn rises on that edge, no done is issued, and rx_data is cleared.
- H = cfg_div+1 (latched value). A half-period tick fires every H cycles while not IDLE. The counter resets to 0 on state entry.
- IDLE: sck=cfg_cpol (live, so sck settles before csn falls). csn=1.
  - start=1: latch cpol/cpha/div/tx_data into shift register; go to LEAD.
  - CPHA=0: mosi=tx_data[DATA_W-1] on entry to LEAD.
- LEAD: csn=0 for one H.
- XFER: sck toggles on each tick, for exactly 2*DATA_W edges, then TRAIL.
  - Edge k (k=1..2*DATA_W) occurs at the end of the k-th half-period counted from LEAD entry.
  - Odd edges are leading, even edges are trailing.
  - CPHA=0: leading edge samples miso into the rx shift register (shift left, LSB in). Trailing edge drives the next tx bit on mosi, except after the last bit, where mosi holds.
  - CPHA=1: leading edge drives the next tx bit on mosi (MSB first). Trailing edge samples miso.
- TRAIL: sck=cpol, csn=0 for one H. Then csn=1, rx_data<=rx shift register, done=1 for exactly one cycle; go to GAP.
- GAP: csn=1 for one H (minimum deselect time). Then busy=0; go to IDLE.
- csn low duration is exactly (2*DATA_W+1)*H cycles. busy is high for (2*DATA_W+2)*H cycles.
- start while busy=1 is ignored, with no side effects. start on the cycle busy falls is accepted.
- Config or tx_data changes while busy have no effect on the current transfer.
- cfg_div=0 gives sck=clk/2. cfg_div=2^DIV_W-1 gives the maximum period; the counter must not wrap early.
- mosi after a transfer holds the last driven bit until the next start. Verification must not check mosi while csn=1.

Decomposition:
- Shared defines include spi_master_defines.v:
  - state encodings (IDLE, LEAD, XFER, TRAIL, GAP);
  - mode encoding {cpol,cpha}, with 1..4 matching the bench mode-select values (1=00, 2=10, 3=01, 4=11).
- One sub-module, spi_clk_gen: half-period counter with en/clear inputs and a tick output. The state machine, shift registers and I/O stay in spi_master.

Test Plan:
- Mode 0, div=1, tx=0xA5, slave model returns 0x3C:
  - slave receives 0xA5, rx_data=0x3C;
  - csn low exactly 34 cycles;
  - done is a single pulse, and busy falls 2 cycles later.
- Modes 1/2/3 (cpol/cpha 10, 01, 11), tx=0x5A, slave returns 0xC3 → slave receives 0x5A, rx_data=0xC3 in every mode, and sck idles at the cpol level before and after csn.
- div=0 and div=255, tx=0xFF, miso tied 0 → rx_data=0x00, sck period is 2 and 512 cycles respectively, and there is no early counter wrap.
- start pulsed mid-transfer with tx=0x11 during a 0xA5 transfer → the in-flight transfer is unaffected, no second csn fall occurs, and exactly one done is issued.
- rstn low for 1 cycle at edge 7 of a transfer → csn=1 and sck=0 on the next cycle, no done, rx_data=0. A following start with tx=0x81 completes normally.
- Back-to-back: start asserted in the cycle busy falls, two words 0x01 then 0x80 → two done pulses, and csn high for at least H cycles between the two transfers.
